sram_ctrl: RTL

Synchronous initiator that drives the 2K x 8 asynchronous SRAM (HM-65162 pin set: Address, Data, SRG, SRE, SRW) on behalf of a single-clock host. It converts one-cycle host requests into correctly sequenced chip-enable, output-enable and write-enable pulses whose widths are integer clock counts that meet the SRAM's ns minimums. It owns the bidirectional Data bus and guarantees bus turnaround after reads.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_ctrl_timer.sv | 16 +
 rtl/sram_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: states, widths and default cycle counts for the HM-65162 SRAM initiator
package sram_ctrl_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int CNT_W = 4;
  localparam int T_AS = 1;
  localparam int T_WP = 6;
  localparam int T_WH = 2;
  localparam int T_RD = 10;
  localparam int T_TURN = 5;
  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, TURN
`ifdef SRAM_CTRL_FAST_READ_EN
    , R_GAP
`endif
  } state_t;
  function automatic logic [CNT_W-1:0] ticks(input int t);
    return CNT_W'(t - 1);
  endfunction
endpackage

// File: rtl/sram_ctrl_timer.sv
// sram_ctrl_timer: loadable down-counter that parks at zero and flags it
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? loadVal : (zero ? cnt : cnt - 1'b1);
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: HM-65162 SRAM initiator with registered strobes; SRAM_CTRL_FAST_READ_EN adds the R_GAP back-to-back read state
module sram_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  output logic              SRE,
  output logic              SRG,
  output logic              SRW
);
  state_t state, nextState;
  logic accept, load, zero, drive, sample;
  logic [CNT_W-1:0] loadVal, turnVal;
  logic [DATA_W-1:0] dataOut;
`ifdef SRAM_CTRL_FAST_READ_EN
  logic pendWrite;
  assign ready = state == IDLE || state == R_GAP;
  assign turnVal = ticks(T_TURN - 1);
`else
  assign ready = state == IDLE;
  assign turnVal = ticks(T_TURN);
`endif
  assign accept = req && ready;
  assign sample = state == R_ACCESS && zero;
  assign load = nextState != state;
  assign Data = drive ? dataOut : 'z;
  sram_ctrl_timer timer (.clk(clk), .rst_n(rst_n), .load(load), .loadVal(loadVal), .zero(zero));
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = req ? (we ? W_SETUP : R_ACCESS) : IDLE;
      W_SETUP:  nextState = zero ? W_PULSE : W_SETUP;
      W_PULSE:  nextState = zero ? W_HOLD : W_PULSE;
      W_HOLD:   nextState = zero ? IDLE : W_HOLD;
`ifdef SRAM_CTRL_FAST_READ_EN
      R_ACCESS: nextState = zero ? R_GAP : R_ACCESS;
      TURN:     nextState = zero ? (pendWrite ? W_SETUP : IDLE) : TURN;
      R_GAP:    nextState = req && !we ? R_ACCESS : TURN;
`else
      R_ACCESS: nextState = zero ? TURN : R_ACCESS;
      TURN:     nextState = zero ? IDLE : TURN;
`endif
      default:  nextState = IDLE;
    endcase
    loadVal = nextState == W_SETUP  ? ticks(T_AS) :
              nextState == W_PULSE  ? ticks(T_WP) :
              nextState == W_HOLD   ? ticks(T_WH) :
              nextState == R_ACCESS ? ticks(T_RD) :
              nextState == TURN     ? turnVal : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // Strobes are registered from nextState so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Address <= '0;
      dataOut <= '0;
      drive   <= 1'b0;
      SRE     <= 1'b1;
      SRG     <= 1'b1;
      SRW     <= 1'b1;
      rdata   <= '0;
      rvalid  <= 1'b0;
`ifdef SRAM_CTRL_FAST_READ_EN
      pendWrite <= 1'b0;
`endif
    end else begin
      if (accept) Address <= addr;
      if (accept && we) dataOut <= wdata;
`ifdef SRAM_CTRL_FAST_READ_EN
      if (accept) pendWrite <= we && state == R_GAP;
`endif
      drive  <= nextState inside {W_SETUP, W_PULSE, W_HOLD};
      SRE    <= !(nextState inside {W_SETUP, W_PULSE, R_ACCESS});
      SRG    <= nextState != R_ACCESS;
      SRW    <= nextState != W_PULSE;
      rvalid <= sample;
      if (sample) rdata <= Data;
    end
endmodule
